// File: rtl/xor_stream_cipher.sv
// Packet-level XOR stream cipher with a programmable key file and optional ciphertext chaining.
// The same instance both encrypts and decrypts; the stream interface is valid/ready with a registered output.
//
// state | meaning
// IDLE  | waiting for Start; key-file writes allowed
// RUN   | accepting input words
// DRAIN | last word accepted, waiting for its output handshake
// DONE  | one-cycle completion pulse
module xor_stream_cipher #(
  parameter int DATA_W    = 8,
  parameter int KEY_DEPTH = 16,
  parameter int LEN_W     = 8,
  localparam int KIDX_W   = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              KeyWe,
  input  logic [KIDX_W-1:0] KeyAddr,
  input  logic [DATA_W-1:0] KeyData,
  input  logic [KIDX_W:0]   NumKeys,
  input  logic [1:0]        Mode,
  input  logic [DATA_W-1:0] Iv,
  input  logic [LEN_W-1:0]  Size,
  input  logic              Start,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              InValid,
  output logic              InReady,
  output logic [DATA_W-1:0] DataOut,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              Ready,
  output logic              Done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [KIDX_W:0] KEY_DEPTH_N = (KIDX_W+1)'(KEY_DEPTH);

  state_t state_q, state_d;

  logic [DATA_W-1:0] key_q [KEY_DEPTH];
  logic [DATA_W-1:0] key_d [KEY_DEPTH];
  logic [KIDX_W-1:0] idx_q, idx_d;
  logic [KIDX_W:0]   nkeys_q, nkeys_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] chain_q, chain_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovalid_q, ovalid_d;

  logic              accept;
  logic [DATA_W-1:0] xor_key;

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = (Size == '0) ? S_DONE : S_RUN;
      S_RUN:   if (accept && rem_q == LEN_W'(1)) state_d = S_DRAIN;
      S_DRAIN: if (ovalid_q && OutReady) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    InReady = (state_q == S_RUN) && (!ovalid_q || OutReady);
    accept  = InValid && InReady;
    Ready   = (state_q == S_IDLE) || (state_q == S_DONE);
    Done    = (state_q == S_DONE);
  end

  assign xor_key = DataIn ^ key_q[idx_q];

  always_comb begin
    key_d    = key_q;
    idx_d    = idx_q;
    nkeys_d  = nkeys_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    chain_d  = chain_q;
    dout_d   = dout_q;
    ovalid_d = ovalid_q;

    if (state_q == S_IDLE && Start) begin
      rem_d   = Size;
      mode_d  = Mode;
      chain_d = Iv;
      idx_d   = '0;
      if (NumKeys == '0)              nkeys_d = (KIDX_W+1)'(1);
      else if (NumKeys > KEY_DEPTH_N) nkeys_d = KEY_DEPTH_N;
      else                            nkeys_d = NumKeys;
    end

    // Out-of-range addresses match no entry and are dropped.
    if (state_q == S_IDLE && KeyWe) begin
      for (int i = 0; i < KEY_DEPTH; i++) begin
        if (KeyAddr == KIDX_W'(i)) key_d[i] = KeyData;
      end
    end

    if (accept) begin
      case (mode_q)
        2'b01: begin
          dout_d  = xor_key ^ chain_q;
          chain_d = xor_key ^ chain_q;
        end
        2'b10: begin
          dout_d  = xor_key ^ chain_q;
          chain_d = DataIn;
        end
        default: dout_d = xor_key;
      endcase
      ovalid_d = 1'b1;
      if (rem_q != '0) rem_d = rem_q - LEN_W'(1);
      if ({1'b0, idx_q} == nkeys_q - (KIDX_W+1)'(1)) idx_d = '0;
      else                                           idx_d = idx_q + KIDX_W'(1);
    end else if (ovalid_q && OutReady) begin
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < KEY_DEPTH; i++) key_q[i] <= '0;
      idx_q    <= '0;
      nkeys_q  <= '0;
      rem_q    <= '0;
      mode_q   <= '0;
      chain_q  <= '0;
      dout_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      key_q    <= key_d;
      idx_q    <= idx_d;
      nkeys_q  <= nkeys_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      chain_q  <= chain_d;
      dout_q   <= dout_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign DataOut  = dout_q;
  assign OutValid = ovalid_q;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Scoreboard bench for xor_stream_cipher, built with a five-entry key file so out-of-range
// key addresses and NumKeys clamping are reachable.
module tb_xor_stream_cipher;
  localparam int DW = 8;
  localparam int KD = 5;
  localparam int LW = 8;
  localparam int KW = 3;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          KeyWe = 1'b0;
  logic [KW-1:0] KeyAddr = '0;
  logic [DW-1:0] KeyData = '0;
  logic [KW:0]   NumKeys = '0;
  logic [1:0]    Mode = '0;
  logic [DW-1:0] Iv = '0;
  logic [LW-1:0] Size = '0;
  logic          Start = 1'b0;
  logic [DW-1:0] DataIn = '0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [DW-1:0] DataOut;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic          Ready;
  logic          Done;

  xor_stream_cipher #(.DATA_W(DW), .KEY_DEPTH(KD), .LEN_W(LW)) dut (
    .Clk(Clk), .Reset(Reset), .KeyWe(KeyWe), .KeyAddr(KeyAddr), .KeyData(KeyData),
    .NumKeys(NumKeys), .Mode(Mode), .Iv(Iv), .Size(Size), .Start(Start),
    .DataIn(DataIn), .InValid(InValid), .InReady(InReady), .DataOut(DataOut),
    .OutValid(OutValid), .OutReady(OutReady), .Ready(Ready), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_out_hs = 0;
  logic [7:0] exp_q[$];
  logic [7:0] key_m[KD];
  bit         hold_v = 1'b0;
  logic [7:0] hold_d = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake pops one expected word.
  always @(negedge Clk) begin
    if (hold_v && OutValid) check("hold_stable", 32'(DataOut), 32'(hold_d));
    if (OutValid && OutReady) begin
      n_out_hs++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL extra_word: got %0h expected no output", DataOut);
      end else begin
        check("data", 32'(DataOut), 32'(exp_q.pop_front()));
      end
    end
    hold_v = OutValid && !OutReady;
    hold_d = DataOut;
  end

  task automatic write_key(input int a, input logic [7:0] d);
    @(posedge Clk); #1;
    KeyWe = 1'b1; KeyAddr = KW'(a); KeyData = d;
    @(posedge Clk); #1;
    KeyWe = 1'b0;
    if (a < KD) key_m[a] = d;
  endtask

  task automatic end_checks();
    @(posedge Clk); #1;
    Start = 1'b0; KeyWe = 1'b0; InValid = 1'b0;
    check("done_pulse", 32'(Done), 1);
    check("ready_done", 32'(Ready), 1);
    check("ovalid_done", 32'(OutValid), 0);
    @(posedge Clk); #1;
    check("done_clear", 32'(Done), 0);
    check("ready_idle", 32'(Ready), 1);
  endtask

  task automatic run_packet(input logic [1:0] md, input logic [7:0] iv, input logic [3:0] nk,
                            input logic [7:0] dq[$], input int in_p, input int out_p, input bit noise);
    int nke, i, cyc, hb, sz;
    logic [7:0] ch, r, k;
    sz  = dq.size();
    nke = (nk == 0) ? 1 : ((int'(nk) > KD) ? KD : int'(nk));
    ch  = iv;
    for (int j = 0; j < sz; j++) begin
      k = key_m[j % nke];
      case (md)
        2'b01: begin r = dq[j] ^ k ^ ch; ch = r; end
        2'b10: begin r = dq[j] ^ k ^ ch; ch = dq[j]; end
        default: r = dq[j] ^ k;
      endcase
      exp_q.push_back(r);
    end
    n_out_hs = 0;
    @(posedge Clk); #1;
    Start = 1'b1; Mode = md; Iv = iv; NumKeys = nk; Size = LW'(sz);
    i = 0;
    cyc = 0;
    while (n_out_hs < sz && cyc < 40 * sz + 50) begin
      @(posedge Clk); #1;
      cyc++;
      hb = n_out_hs;
      Start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        KeyWe   = 1'($urandom_range(0, 1));
        KeyAddr = KW'($urandom);
        KeyData = DW'($urandom);
        Mode    = 2'($urandom);
        Iv      = DW'($urandom);
        NumKeys = (KW+1)'($urandom);
        Size    = LW'($urandom);
      end
      InValid  = (i < sz) && ($urandom_range(0, 99) < in_p);
      DataIn   = (i < sz) ? dq[i] : DW'($urandom);
      OutReady = ($urandom_range(0, 99) < out_p);
      check("ready_low", 32'(Ready), 0);
      @(negedge Clk); #1;
      check("out_valid", 32'(OutValid), 32'(i > hb));
      check("in_ready", 32'(InReady), 32'((i < sz) && (!(i > hb) || OutReady)));
      if (InValid && InReady) i++;
    end
    if (n_out_hs < sz) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got %0d outputs expected %0d", n_out_hs, sz);
    end
    if (in_p == 100 && out_p == 100) check("throughput_cycles", 32'(cyc), 32'(sz + 1));
    end_checks();
    check("queue_empty", 32'(exp_q.size()), 0);
  endtask

  logic [7:0] q[$];

  task automatic rand_q(input int n);
    q.delete();
    for (int j = 0; j < n; j++) q.push_back(8'($urandom));
  endtask

  initial begin
    for (int j = 0; j < KD; j++) key_m[j] = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_dataout", 32'(DataOut), 0);
    check("rst_ovalid", 32'(OutValid), 0);
    check("rst_inready", 32'(InReady), 0);
    check("rst_ready", 32'(Ready), 1);
    check("rst_done", 32'(Done), 0);
    Reset = 1'b0;

    // Single key, plain XOR
    write_key(0, 8'h5A);
    q = '{8'h00, 8'hFF, 8'h3C};
    run_packet(2'b00, 8'h00, 4'd1, q, 100, 100, 1'b0);

    // Key wrap, restart at key[0], NumKeys=0 clamps to one key
    write_key(0, 8'h01); write_key(1, 8'h02); write_key(2, 8'h03);
    q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_packet(2'b00, 8'h00, 4'd3, q, 100, 100, 1'b0);
    run_packet(2'b00, 8'h00, 4'd3, q, 100, 100, 1'b0);
    write_key(0, 8'h77);
    rand_q(6);
    run_packet(2'b00, 8'h00, 4'd0, q, 100, 100, 1'b0);

    // Chaining round trip, and mode 11 behaving as plain
    write_key(0, 8'h0F);
    q = '{8'h01, 8'h02};
    run_packet(2'b01, 8'h10, 4'd1, q, 100, 100, 1'b0);
    q = '{8'h1E, 8'h13};
    run_packet(2'b10, 8'h10, 4'd1, q, 100, 100, 1'b0);
    for (int j = 0; j < KD; j++) write_key(j, 8'($urandom));
    rand_q(7);
    run_packet(2'b11, 8'h00, 4'd4, q, 100, 100, 1'b0);

    // Backpressure and random flow control, NumKeys above depth clamps
    rand_q(12);
    run_packet(2'b00, 8'h00, 4'd2, q, 100, 30, 1'b0);
    rand_q(200);
    run_packet(2'($urandom), 8'($urandom), 4'd7, q, 70, 60, 1'b0);
    rand_q(40);
    run_packet(2'b01, 8'($urandom), 4'd5, q, 80, 50, 1'b0);
    rand_q(40);
    run_packet(2'b10, 8'($urandom), 4'd3, q, 60, 80, 1'b0);

    // Size zero: Done after one cycle, no output
    @(posedge Clk); #1;
    Start = 1'b1; Size = '0; OutReady = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    check("size0_done", 32'(Done), 1);
    check("size0_ready", 32'(Ready), 1);
    check("size0_ovalid", 32'(OutValid), 0);
    @(posedge Clk); #1;
    check("size0_done_clear", 32'(Done), 0);
    check("size0_ovalid2", 32'(OutValid), 0);

    // Start/KeyWe/config noise mid-packet must not disturb it or the key file
    rand_q(30);
    run_packet(2'b01, 8'h3C, 4'd5, q, 80, 70, 1'b1);
    rand_q(10);
    run_packet(2'b00, 8'h00, 4'd5, q, 100, 100, 1'b0);

    // Out-of-range key addresses are dropped
    write_key(5, 8'hEE); write_key(6, 8'hDD); write_key(7, 8'hCC);
    rand_q(10);
    run_packet(2'b00, 8'h00, 4'd5, q, 100, 100, 1'b0);

    // Reset after two of four words
    @(posedge Clk); #1;
    Start = 1'b1; Size = 8'd4; Mode = 2'b00; NumKeys = 4'd5; OutReady = 1'b1;
    exp_q.push_back(8'h11 ^ key_m[0]);
    @(posedge Clk); #1;
    Start = 1'b0; InValid = 1'b1; DataIn = 8'h11;
    @(posedge Clk); #1;
    DataIn = 8'h22;
    @(posedge Clk); #1;
    InValid = 1'b0; OutReady = 1'b0; Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("rst_mid_ovalid", 32'(OutValid), 0);
    check("rst_mid_ready", 32'(Ready), 1);
    check("rst_mid_done", 32'(Done), 0);
    check("rst_mid_queue", 32'(exp_q.size()), 0);
    for (int j = 0; j < KD; j++) key_m[j] = '0;
    rand_q(8);
    run_packet(2'b00, 8'h00, 4'd5, q, 100, 100, 1'b0);
    for (int j = 0; j < KD; j++) write_key(j, 8'($urandom));
    rand_q(20);
    run_packet(2'b01, 8'($urandom), 4'd5, q, 90, 80, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
